fp_mantissa_normalizer: RTL and testbench

//  Post-add/subtract normalizer for the half-precision (IEEE-754 binary16) calculator datapath.
//  It is the inverse of the pre-add alignment step, which right-shifts the smaller operand's mantissa.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_rounder.sv | 32 +++
 rtl/fp_mantissa_normalizer.sv | 94 +++++++++
 tb/tb_fp_mantissa_normalizer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary16 constants, the packed result type and the normalizer state encoding.
// Used by the adder/align path as well as the post-add normalizer.
package fp_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int GRS_W    = 3;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;
  localparam int MANT_W   = MAN_W + 2 + GRS_W;

  // Exponents carry one spare bit internally so carry/round increments past 31 stay visible.
  localparam logic [EXP_W:0]   EXP_INC  = (EXP_W+1)'(1);
  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } norm_state_e;

  function automatic fp16_t signed_zero(input logic s);
    return '{sign: s, exp: '0, frac: '0};
  endfunction

endpackage

// File: rtl/fp_rounder.sv
// Combinational rounding of a normalized 1.f mantissa with G/R/S bits.
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the G/R/S bits are truncated.
module fp_rounder
  import fp_pkg::*;
(
  input  logic [MAN_W+GRS_W:0] mant_i,
  input  logic [EXP_W:0]       exp_i,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W-1:0]     frac_o,
  output logic                 ovf_o
);

  logic             inc;
  logic [MAN_W+1:0] sum;
  logic [EXP_W:0]   exp_r;

`ifdef ROUND_NEAREST_EN
  assign inc = mant_i[2] & (mant_i[1] | mant_i[0] | mant_i[3]);
`else
  logic unused_grs;
  assign unused_grs = ^mant_i[2:0];
  assign inc        = 1'b0;
`endif

  // Increment on {0, hidden, frac}; the top bit flags the 1.11..1 -> 10.0 overflow.
  assign sum    = {1'b0, mant_i[MAN_W+GRS_W:GRS_W]} + {{(MAN_W+1){1'b0}}, inc};
  assign exp_r  = sum[MAN_W+1] ? exp_i + EXP_INC : exp_i;
  assign frac_o = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign exp_o  = exp_r[EXP_W-1:0];
  assign ovf_o  = exp_r >= (EXP_W+1)'(EXP_MAX);

endmodule

// File: rtl/fp_mantissa_normalizer.sv
// Post-add normalizer: shifts the raw sum mantissa into 1.f form one bit per cycle, rounds, packs binary16.
// Rounding mode comes from the fp_rounder build option ROUND_NEAREST_EN (truncation when undefined).
module fp_mantissa_normalizer
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so they are never high together.
  norm_state_e       state_q;
  logic              sign_q;
  logic [EXP_W:0]    exp_q;
  logic [MANT_W-1:0] mant_q;
  fp16_t             res_q;

  logic [EXP_W-1:0]  rnd_exp;
  logic [MAN_W-1:0]  rnd_frac;
  logic              rnd_ovf;

  fp_rounder u_rounder (
    .mant_i (mant_q[MAN_W+GRS_W:0]),
    .exp_i  (exp_q),
    .exp_o  (rnd_exp),
    .frac_o (rnd_frac),
    .ovf_o  (rnd_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= {1'b0, in_exp};
            mant_q  <= in_mant;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (mant_q == '0) begin
            res_q   <= signed_zero(sign_q);
            state_q <= DONE;
          end else if (mant_q[MANT_W-1]) begin
            // Carry: the bit shifted out of R must stay folded into sticky.
            mant_q  <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
            exp_q   <= exp_q + EXP_INC;
            state_q <= ROUND;
          end else if (mant_q[MANT_W-2]) begin
            state_q <= ROUND;
          end else if (exp_q <= EXP_INC) begin
            // No denormals: anything that would need exp 0 flushes to signed zero.
            res_q   <= signed_zero(sign_q);
            state_q <= DONE;
          end else begin
            mant_q  <= {mant_q[MANT_W-2:0], 1'b0};
            exp_q   <= exp_q - EXP_INC;
          end
        end
        ROUND: begin
          if (rnd_ovf) res_q <= '{sign: sign_q, exp: EXP_ALL1, frac: '0};
          else         res_q <= '{sign: sign_q, exp: rnd_exp, frac: rnd_frac};
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_mantissa_normalizer.sv
// Directed bench for the binary16 post-add normalizer; expected values are hand-computed.
module tb_fp_mantissa_normalizer;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [14:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [1:0]  dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [4:0] e_one;
  logic [15:0] held;

  fp_mantissa_normalizer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operation, keep in_valid high with junk while busy, measure latency, check, drain.
  task automatic run_op(input string tag, input logic s, input logic [4:0] e,
                        input logic [14:0] m, input logic [15:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_mant  = 15'($urandom_range(0, 32767));
    in_exp   = 5'($urandom_range(0, 31));
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, ".lat"}, 16'(lat), 16'(exp_lat));
    chk({tag, ".busy_ready"}, {15'b0, in_ready}, 16'h0000);
    chk({tag, ".res"}, out_result, exp_res);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".idle"}, {14'b0, in_ready, out_valid}, 16'h0002);
  endtask

  initial begin
    e_one     = 5'(EXP_BIAS);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.result", out_result, 16'h0000);
    chk("rst.flags", {14'b0, in_ready, out_valid}, 16'h0002);
    chk("rst.state", {14'b0, dbg_state}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    run_op("one",       1'b0, e_one, 15'b0_1_0000000000_000, 16'h3C00, 3);
    run_op("carry",     1'b0, 5'd15, 15'b1_0_0000000000_000, 16'h4000, 3);
    run_op("lshift3",   1'b0, 5'd15, 15'b0_0_0010000000_000, 16'h3000, 6);
    run_op("lshift10",  1'b0, 5'd20, 15'b0_0_0000000001_000, 16'h2800, 13);
    run_op("neg_inf",   1'b1, 5'd30, 15'b1_0_0000000000_000, 16'hFC00, 3);
    run_op("flush",     1'b1, 5'd1,  15'b0_0_1000000000_000, 16'h8000, 2);
    run_op("zero",      1'b1, 5'd20, 15'b0_0_0000000000_000, 16'h8000, 2);
    run_op("exp0",      1'b0, 5'd0,  15'b0_0_0000000001_000, 16'h0000, 2);
    run_op("exp31",     1'b0, 5'd31, 15'b0_1_0000000101_000, 16'h7C00, 3);
    run_op("tie_even",  1'b0, 5'd15, 15'b0_1_0000000000_100, 16'h3C00, 3);
`ifdef ROUND_NEAREST_EN
    run_op("rnd_all1",  1'b0, 5'd15, 15'b0_1_1111111111_100, 16'h4000, 3);
    run_op("tie_odd",   1'b0, 5'd15, 15'b0_1_0000000001_100, 16'h3C02, 3);
    run_op("sticky",    1'b0, 5'd15, 15'b1_0_0000000001_001, 16'h4001, 3);
    run_op("rnd_inf",   1'b0, 5'd30, 15'b0_1_1111111111_110, 16'h7C00, 3);
`else
    run_op("rnd_all1",  1'b0, 5'd15, 15'b0_1_1111111111_100, 16'h3FFF, 3);
    run_op("tie_odd",   1'b0, 5'd15, 15'b0_1_0000000001_100, 16'h3C01, 3);
    run_op("sticky",    1'b0, 5'd15, 15'b1_0_0000000001_001, 16'h4000, 3);
    run_op("rnd_inf",   1'b0, 5'd30, 15'b0_1_1111111111_110, 16'h7BFF, 3);
`endif

    // Backpressure: result must hold while out_ready stays low.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 5'd15;
    in_mant  = 15'b1_0_0000000000_000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("hold.valid", {15'b0, out_valid}, 16'h0001);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold.result", out_result, 16'h4000);
      chk("hold.ready", {14'b0, in_ready, out_valid}, 16'h0001);
    end
    chk("hold.same", out_result, held);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold.release", {14'b0, in_ready, out_valid}, 16'h0002);

    // Asynchronous reset while shifting in NORM.
    @(negedge clk);
    in_exp   = 5'd15;
    in_mant  = 15'b0_0_0010000000_000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.state", {14'b0, dbg_state}, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.flags", {14'b0, in_ready, out_valid}, 16'h0002);
    chk("mid.state_idle", {14'b0, dbg_state}, 16'h0000);
    chk("mid.result", out_result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", 1'b1, 5'd15, 15'b0_1_1000000000_000, 16'hBE00, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
